instr_queue: RTL and testbench
==============================

// Module: instr_queue
// PURPOSE
//  Fetch-to-dispatch decoupling FIFO. Captures every valid instruction that the fetch unit delivers,
//  together with its PC and its predicted nPC. Presents them in order to dispatch through a
//  valid/ready handshake. Backpressures fetch through stall_fetch and drops all contents on a
//  ROB-driven restart.
// PARAMETERS
//  IQ_DEPTH      4   entries; power of 2, >= 2
//  LOG_IQ_DEPTH  2   $clog2(IQ_DEPTH); pointer index width
// PORTS
//  CLK                 in   1      clock
//  RST                 in   1      synchronous, active-high reset
//  fetch_ivalid        in   1      fetch delivers an instruction this cycle
//  fetch_instr         in   32     instruction word (word_t)
//  fetch_PC            in   14     PC of the instruction (pc_t, word address)
//  fetch_nPC           in   14     PC predicted by fetch to follow this instruction (pc_t)
//  stall_fetch         out  1      queue full; fetch must not deliver
//  flush               in   1      restart (take_resolved); discard all entries
//  dispatch_ready      in   1      dispatch consumes the head this cycle if dispatch_valid
//  dispatch_valid      out  1      head entry valid
//  dispatch_instr      out  32     head instruction
//  dispatch_PC         out  14     head PC
//  dispatch_nPC        out  14     head predicted nPC
//  iq_count            out  LOG_IQ_DEPTH+1  occupancy, 0..IQ_DEPTH
//  DUT_error           out  1      registered; sticky until reset
// BEHAVIOUR
//  - Reset (RST high at posedge):
//    - head/tail pointers = 0, count = 0, DUT_error = 0.
//    - Outputs then read dispatch_valid = 0, stall_fetch = 0, iq_count = 0.
//    - Entry storage is not reset; it is don't-care while invalid.
//  - Pointers are LOG_IQ_DEPTH+1 bits wide. The MSB is the wrap bit.
//    - full  = (idx equal) & (wrap bits differ).
//    - empty = pointers equal.
//    - Increments wrap naturally modulo 2*IQ_DEPTH.
//  - stall_fetch = full. It is purely a function of registered state, with no combinational path
//    from dispatch_ready.
//  - enq = fetch_ivalid & ~full & ~flush.
//    - Writes the entry at the tail index and advances tail at the posedge.
//  - deq = dispatch_valid & dispatch_ready.
//    - Advances head at the posedge.
//  - dispatch_valid = ~empty & ~flush.
//    - dispatch_* outputs are read combinationally from the head entry.
//  - Latency: an entry enqueued at edge N is visible at the head from edge N onward. There is no
//    same-cycle fall-through from fetch to dispatch.
//  - enq and deq in the same cycle:
//    - Both take effect and count is unchanged.
//    - This is legal at any non-full, non-empty occupancy.
//    - When full, enq is blocked even if deq fires. This is accepted bubble cost.
//  - flush dominates:
//    - Next state is head = tail = 0, count = 0.
//    - Any same-cycle fetch_ivalid and dispatch handshake are ignored.
//    - Entries are not written.
//  - fetch_ivalid while full and ~flush: the instruction is dropped and DUT_error is set next cycle.
//  - Reset during any operation: RST overrides flush and the handshakes, with the reset values above.
//  - iq_count = tail - head (LOG_IQ_DEPTH+1 bit subtraction). It equals IQ_DEPTH when full.
// STRUCTURE
//  - core_types_pkg additions:
//    - IQ_DEPTH and LOG_IQ_DEPTH constants.
//    - iq_entry_t packed struct {word_t instr; pc_t PC; pc_t nPC;}.
//    - iq_ptr_t = logic [LOG_IQ_DEPTH:0].
//  - Existing word_t and pc_t are reused.
//  - No sub-module.
//    - One storage array with registered pointers and error flag in the seq block.
//    - One comb block for enq/deq/flush next-state.
// TESTING
//  1 Reset, then fetch_ivalid=1 with instr=32'h2000_0001, PC=14'h10, nPC=14'h11, dispatch_ready=0
//    -> next cycle: dispatch_valid=1, dispatch_PC=14'h10, dispatch_nPC=14'h11, iq_count=1.
//  2 Fill with PCs 1..4, ready=0 -> iq_count=4, stall_fetch=1.
//    Then ready=1 for 4 cycles -> PCs 1,2,3,4 in order, then dispatch_valid=0 and stall_fetch=0.
//  3 Steady stream at occupancy 2, fetch_ivalid=1 and ready=1 for 10 cycles
//    -> iq_count stays 2, PCs in order, pointers wrap past index 3 with no loss.
//  4 Queue holds 3 entries; assert flush with fetch_ivalid=1 and ready=1
//    -> that cycle dispatch_valid=0; next cycle iq_count=0, no entry written, DUT_error=0.
//  5 Queue full; fetch_ivalid=1 and ready=0 -> next cycle DUT_error=1 and contents unchanged.
//    DUT_error stays 1 until RST.
//  6 Queue holding 2 entries; RST=1 for 1 cycle while fetch_ivalid=1
//    -> iq_count=0, dispatch_valid=0, stall_fetch=0, DUT_error=0.

Source files
------------

// File: rtl/core_types_pkg.sv
// Shared core datatypes: machine word, word-addressed PC, and instruction-queue types.
package core_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [13:0] pc_t;

  localparam int unsigned IQ_DEPTH     = 4;
  localparam int unsigned LOG_IQ_DEPTH = $clog2(IQ_DEPTH);

  typedef struct packed {
    word_t instr;
    pc_t   PC;
    pc_t   nPC;
  } iq_entry_t;

  // Extra MSB is the wrap bit that separates full from empty.
  typedef logic [LOG_IQ_DEPTH:0] iq_ptr_t;

endpackage

// File: rtl/instr_queue.sv
// Fetch-to-dispatch decoupling FIFO with flush and sticky overflow error.
module instr_queue
  import core_types_pkg::*;
(
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    fetch_ivalid,
  input  logic [31:0]             fetch_instr,
  input  logic [13:0]             fetch_PC,
  input  logic [13:0]             fetch_nPC,
  output logic                    stall_fetch,
  input  logic                    flush,
  input  logic                    dispatch_ready,
  output logic                    dispatch_valid,
  output logic [31:0]             dispatch_instr,
  output logic [13:0]             dispatch_PC,
  output logic [13:0]             dispatch_nPC,
  output logic [LOG_IQ_DEPTH:0]   iq_count,
  output logic                    DUT_error
);

  iq_entry_t mem_q [IQ_DEPTH];
  iq_ptr_t   head_q, head_d;
  iq_ptr_t   tail_q, tail_d;
  logic      err_q, err_d;

  logic      full, empty, enq, deq;
  iq_entry_t head_entry;

  assign full  = (head_q[LOG_IQ_DEPTH-1:0] == tail_q[LOG_IQ_DEPTH-1:0]) &&
                 (head_q[LOG_IQ_DEPTH] != tail_q[LOG_IQ_DEPTH]);
  assign empty = (head_q == tail_q);

  assign enq = fetch_ivalid & ~full & ~flush;
  assign deq = dispatch_valid & dispatch_ready;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    err_d  = err_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      if (enq) tail_d = tail_q + iq_ptr_t'(1);
      if (deq) head_d = head_q + iq_ptr_t'(1);
      // An instruction offered while full is lost; record it permanently.
      if (fetch_ivalid && full) err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      head_q <= '0;
      tail_q <= '0;
      err_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      err_q  <= err_d;
    end
  end

  // Storage is not reset; contents are meaningless outside head..tail.
  always_ff @(posedge CLK) begin
    if (enq && !RST) begin
      mem_q[tail_q[LOG_IQ_DEPTH-1:0]] <= '{instr: fetch_instr, PC: fetch_PC, nPC: fetch_nPC};
    end
  end

  assign head_entry     = mem_q[head_q[LOG_IQ_DEPTH-1:0]];
  assign dispatch_valid = ~empty & ~flush;
  assign dispatch_instr = head_entry.instr;
  assign dispatch_PC    = head_entry.PC;
  assign dispatch_nPC   = head_entry.nPC;
  assign stall_fetch    = full;
  assign iq_count       = tail_q - head_q;
  assign DUT_error      = err_q;

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue: queue-based reference model plus directed scenarios.
module tb_instr_queue;
  import core_types_pkg::*;

  logic                  CLK = 1'b0;
  logic                  RST = 1'b1;
  logic                  fetch_ivalid = 1'b0;
  logic [31:0]           fetch_instr = '0;
  logic [13:0]           fetch_PC = '0;
  logic [13:0]           fetch_nPC = '0;
  logic                  stall_fetch;
  logic                  flush = 1'b0;
  logic                  dispatch_ready = 1'b0;
  logic                  dispatch_valid;
  logic [31:0]           dispatch_instr;
  logic [13:0]           dispatch_PC;
  logic [13:0]           dispatch_nPC;
  logic [LOG_IQ_DEPTH:0] iq_count;
  logic                  DUT_error;

  instr_queue dut (
    .CLK            (CLK),
    .RST            (RST),
    .fetch_ivalid   (fetch_ivalid),
    .fetch_instr    (fetch_instr),
    .fetch_PC       (fetch_PC),
    .fetch_nPC      (fetch_nPC),
    .stall_fetch    (stall_fetch),
    .flush          (flush),
    .dispatch_ready (dispatch_ready),
    .dispatch_valid (dispatch_valid),
    .dispatch_instr (dispatch_instr),
    .dispatch_PC    (dispatch_PC),
    .dispatch_nPC   (dispatch_nPC),
    .iq_count       (iq_count),
    .DUT_error      (DUT_error)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of held entries plus a sticky error bit.
  iq_entry_t mq[$];
  logic      m_err = 1'b0;
  logic      m_live = 1'b0;

  always @(posedge CLK) begin
    if (RST) begin
      mq.delete();
      m_err  = 1'b0;
      m_live = 1'b1;
    end else if (flush) begin
      mq.delete();
    end else begin
      automatic bit was_full = (mq.size() == IQ_DEPTH);
      automatic bit do_deq   = (mq.size() != 0) && dispatch_ready;
      if (fetch_ivalid && was_full) m_err = 1'b1;
      if (do_deq) void'(mq.pop_front());
      if (fetch_ivalid && !was_full) mq.push_back('{fetch_instr, fetch_PC, fetch_nPC});
    end
  end

  always @(negedge CLK) begin
    if (m_live) begin
      automatic bit exp_valid = (mq.size() != 0) && !flush;
      chk("m_valid", 64'(dispatch_valid), 64'(exp_valid));
      chk("m_count", 64'(iq_count), 64'(mq.size()));
      chk("m_stall", 64'(stall_fetch), 64'(mq.size() == IQ_DEPTH));
      chk("m_error", 64'(DUT_error), 64'(m_err));
      if (exp_valid) begin
        chk("m_instr", 64'(dispatch_instr), 64'(mq[0].instr));
        chk("m_pc",    64'(dispatch_PC),    64'(mq[0].PC));
        chk("m_npc",   64'(dispatch_nPC),   64'(mq[0].nPC));
      end
    end
  end

  // Drive one cycle's inputs, cross the edge, and leave time #1 after it.
  task automatic cyc(input logic iv, input logic [31:0] ins, input logic [13:0] pc,
                     input logic [13:0] npc, input logic rdy, input logic fl);
    fetch_ivalid   = iv;
    fetch_instr    = ins;
    fetch_PC       = pc;
    fetch_nPC      = npc;
    dispatch_ready = rdy;
    flush          = fl;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    fetch_ivalid   = 1'b0;
    dispatch_ready = 1'b0;
    flush          = 1'b0;
    #1;
  endtask

  initial begin
    RST = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST = 1'b0;
    idle();
    chk("rst_valid", 64'(dispatch_valid), 64'd0);
    chk("rst_stall", 64'(stall_fetch), 64'd0);
    chk("rst_count", 64'(iq_count), 64'd0);
    chk("rst_error", 64'(DUT_error), 64'd0);

    // 1: single enqueue becomes visible after one edge
    cyc(1'b1, 32'h2000_0001, 14'h10, 14'h11, 1'b0, 1'b0);
    idle();
    chk("t1_valid", 64'(dispatch_valid), 64'd1);
    chk("t1_instr", 64'(dispatch_instr), 64'h2000_0001);
    chk("t1_pc",    64'(dispatch_PC), 64'h10);
    chk("t1_npc",   64'(dispatch_nPC), 64'h11);
    chk("t1_count", 64'(iq_count), 64'd1);
    cyc(1'b0, '0, '0, '0, 1'b1, 1'b0);
    idle();
    chk("t1_drain", 64'(iq_count), 64'd0);

    // 2: fill to full, then drain in order
    for (int i = 1; i <= 4; i++) cyc(1'b1, 32'(i), 14'(i), 14'(i + 1), 1'b0, 1'b0);
    idle();
    chk("t2_count", 64'(iq_count), 64'd4);
    chk("t2_stall", 64'(stall_fetch), 64'd1);
    for (int i = 1; i <= 4; i++) begin
      dispatch_ready = 1'b1;
      #1;
      chk("t2_order", 64'(dispatch_PC), 64'(i));
      @(posedge CLK); #1;
    end
    idle();
    chk("t2_empty", 64'(dispatch_valid), 64'd0);
    chk("t2_nostall", 64'(stall_fetch), 64'd0);

    // 3: steady stream at occupancy 2, wrapping the pointers
    cyc(1'b1, 32'h100, 14'd100, 14'd101, 1'b0, 1'b0);
    cyc(1'b1, 32'h101, 14'd101, 14'd102, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      fetch_ivalid = 1'b1; fetch_instr = 32'(102 + k);
      fetch_PC = 14'(102 + k); fetch_nPC = 14'(103 + k);
      dispatch_ready = 1'b1; flush = 1'b0;
      #1;
      chk("t3_order", 64'(dispatch_PC), 64'(100 + k));
      @(posedge CLK); #1;
      chk("t3_count", 64'(iq_count), 64'd2);
    end
    for (int k = 0; k < 2; k++) begin
      fetch_ivalid = 1'b0; dispatch_ready = 1'b1;
      #1;
      chk("t3_tail", 64'(dispatch_PC), 64'(110 + k));
      @(posedge CLK); #1;
    end
    idle();
    chk("t3_empty", 64'(iq_count), 64'd0);

    // 4: flush with 3 entries beats same-cycle fetch and dispatch
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'(200 + i), 14'(200 + i), 14'(201 + i), 1'b0, 1'b0);
    fetch_ivalid = 1'b1; fetch_PC = 14'd250; dispatch_ready = 1'b1; flush = 1'b1;
    #1;
    chk("t4_flush_valid", 64'(dispatch_valid), 64'd0);
    @(posedge CLK); #1;
    idle();
    chk("t4_count", 64'(iq_count), 64'd0);
    chk("t4_valid", 64'(dispatch_valid), 64'd0);
    chk("t4_error", 64'(DUT_error), 64'd0);
    cyc(1'b1, 32'h300, 14'd300, 14'd301, 1'b0, 1'b0);
    idle();
    chk("t4_refill", 64'(dispatch_PC), 64'd300);
    cyc(1'b0, '0, '0, '0, 1'b1, 1'b0);

    // 5: offer while full -> sticky error, contents untouched
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'(400 + i), 14'(400 + i), 14'(401 + i), 1'b0, 1'b0);
    cyc(1'b1, 32'h499, 14'd499, 14'd500, 1'b0, 1'b0);
    idle();
    chk("t5_error", 64'(DUT_error), 64'd1);
    chk("t5_count", 64'(iq_count), 64'd4);
    chk("t5_head",  64'(dispatch_PC), 64'd400);
    for (int i = 0; i < 4; i++) begin
      dispatch_ready = 1'b1;
      #1;
      chk("t5_order", 64'(dispatch_PC), 64'(400 + i));
      @(posedge CLK); #1;
    end
    idle();
    chk("t5_sticky", 64'(DUT_error), 64'd1);

    // 6: reset while holding 2 entries and fetching
    cyc(1'b1, 32'h600, 14'd600, 14'd601, 1'b0, 1'b0);
    cyc(1'b1, 32'h601, 14'd601, 14'd602, 1'b0, 1'b0);
    RST = 1'b1;
    cyc(1'b1, 32'h602, 14'd602, 14'd603, 1'b1, 1'b0);
    RST = 1'b0;
    idle();
    chk("t6_count", 64'(iq_count), 64'd0);
    chk("t6_valid", 64'(dispatch_valid), 64'd0);
    chk("t6_stall", 64'(stall_fetch), 64'd0);
    chk("t6_error", 64'(DUT_error), 64'd0);

    repeat (2) @(posedge CLK);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
